axi4lite_rr_arbiter: RTL
========================

Name: axi4lite_rr_arbiter

Overview:
- Shares one AXI4-Lite slave port among NUM_M upstream masters.
- Write (AW/W/B) and read (AR/R) paths are arbitrated independently, each with round-robin priority and one outstanding transaction per path.
- Sits between bench/DUT masters and a single AXI4-Lite slave; the downstream side connects to the team's 32-bit-address, 128-bit-data slave interface.

Parameters:
- NUM_M, 2, number of upstream masters (2..8).
- AW, 32, address width.
- DW, 128, data width; strobe width is DW/8.
- TIMEOUT_CYC, 256, response timeout in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- up_awaddr/up_awvalid/up_awready  in/in/out  NUM_M*AW / NUM_M / NUM_M  per-master write address; master i occupies slice i.
- up_wdata/up_wstrb/up_wvalid/up_wready  in/in/in/out  NUM_M*DW / NUM_M*DW/8 / NUM_M / NUM_M  per-master write data.
- up_bresp/up_bvalid/up_bready  out/out/in  NUM_M*2 / NUM_M / NUM_M  per-master write response.
- up_araddr/up_arvalid/up_arready  in/in/out  NUM_M*AW / NUM_M / NUM_M  per-master read address.
- up_rdata/up_rresp/up_rvalid/up_rready  out/out/out/in  NUM_M*DW / NUM_M*2 / NUM_M / NUM_M  per-master read data.
- dn_aw*/dn_w*/dn_b*/dn_ar*/dn_r*  mirrored  AW/DW/DW/8/2  single slave port: awaddr, awvalid, awready, wdata, wstrb, wvalid, wready, bresp, bvalid, bready, araddr, arvalid, arready, rdata, rresp, rvalid, rready.
- wr_grant, rd_grant  out  NUM_M each  one-hot current owner; all-zero when idle.

Behaviour:
- Reset: all valid/ready outputs 0, grants 0, resp/data outputs 0, both FSMs IDLE, both round-robin pointers at master 0.
- Write FSM states are W_IDLE, W_ADDR and W_RESP.
  - W_IDLE: a master requests when awvalid OR wvalid is high. Pick the first requester at or after wr_ptr, wrapping modulo NUM_M. Register the grant and go to W_ADDR on the next edge, so grant latency is 1 cycle.
  - W_ADDR: forward the granted master's AW and W channels combinationally to dn_*, and return dn_awready/dn_wready to that master only. The aw_done and w_done flags set on their respective handshakes and mask the corresponding valid once set. AW and W may complete in the same or different cycles, in either order. When both are done, go to W_RESP.
  - W_RESP: dn_bready = granted up_bready. Route dn_bvalid/dn_bresp to the granted master only. On the B handshake: set wr_ptr = grant+1 (wraps), clear grant, return to W_IDLE.
- Read FSM states are R_IDLE, R_ADDR and R_DATA; same structure using arvalid, AR and R.
- Write and read paths never block each other; simultaneous write and read grants to the same or different masters are legal.
- Non-granted masters see all ready/valid outputs at 0, and their resp/data lanes at 0.
- Requests that arrive while a path is busy wait. A requester that drops its request before grant is simply skipped (not AXI-legal; no error is raised).
- An upstream valid that is held during the arbitration cycle is not consumed until W_ADDR/R_ADDR. There are no combinational paths from up_*valid to up_*ready within the same cycle while in IDLE.
- Reset asserted mid-transaction aborts immediately. Outputs return to reset values and the downstream handshake is abandoned.

Optional Feature:
- Macro: AXI4LITE_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter runs in W_RESP and R_DATA. Reaching TIMEOUT_CYC without dn_bvalid/dn_rvalid causes the block to drive SLVERR (2'b10) with rdata = 0 to the granted master.
  - The block completes that upstream handshake, then returns to IDLE and advances the pointer.
  - While a path is idle after a timeout, dn_bready/dn_rready is held at 1 to sink one late response.
  - Sticky output timeout_err (1 bit) is set; it clears only on reset.
- Without the macro: no counter, no timeout_err port; the block waits forever.

Decomposition:
- Package axi4lite_arb_pkg holds:
  - the RESP_OKAY/RESP_SLVERR constants;
  - the wr_state_t/rd_state_t enums;
  - the default widths.
- One sub-module, axi4lite_rr_pick: a combinational round-robin picker taking a req vector and a pointer, returning a one-hot grant. It is instantiated twice, once for the write path and once for the read path.

Test Plan:
- Single write: master 0 writes addr 0x10, data 0x...AA, strb 0xFFFF; slave returns OKAY. Expect wr_grant = 01 one cycle later, dn_awaddr = 0x10, up_bvalid[0] = 1 with bresp 0, grant back to 0.
- Contention: masters 0 and 1 write simultaneously, three times in a row. Expect grant order 0,1,0,1,0,1 and no dn-side overlap.
- AW/W skew: master 1 presents AW 5 cycles before W. Expect W_RESP entered only after the W handshake, and dn_awvalid low after its handshake.
- Concurrent read and write: master 0 reads 0x20 while master 1 writes 0x30; the slave's rdata = 0x1234 is delivered only to up_rdata lane 0. Both complete independently.
- Reset mid-transaction: assert rst_n low during W_RESP. Expect all outputs 0 asynchronously, and after release wr_ptr = 0 with a fresh arbitration.
- Timeout (macro on, TIMEOUT_CYC = 8): the slave never asserts rvalid. Expect up_rresp = 2'b10 after 8 cycles, timeout_err = 1, and a late rvalid sunk with no upstream pulse.

Source files
------------

// File: rtl/axi4lite_arb_pkg.sv
// Shared definitions for the AXI4-Lite round-robin arbiter.
//   - default widths for the arbiter parameters
//   - AXI response codes
//   - write / read path FSM state encodings
package axi4lite_arb_pkg;

    localparam int DEF_NUM_M       = 2;
    localparam int DEF_AW          = 32;
    localparam int DEF_DW          = 128;
    localparam int DEF_TIMEOUT_CYC = 256;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

endpackage

// File: rtl/axi4lite_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req   in  N   request vector
//   ptr   in  PW  highest-priority index this round
//   grant out N   one-hot winner (zero when no request)
//   idx   out PW  binary index of the winner
//   any   out 1   at least one request present
module axi4lite_rr_pick #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          any
);

    // Scan N positions starting at ptr, wrapping; the first requester wins.
    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = PW'(j);
            end
        end
    end

endmodule

// File: rtl/axi4lite_rr_arbiter.sv
// AXI4-Lite N:1 arbiter. Write (AW/W/B) and read (AR/R) paths are arbitrated
// independently, round-robin, one outstanding transaction per path.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   up_aw*/up_w*/up_b*         per-master write channels, master i in slice i
//   up_ar*/up_r*               per-master read channels, master i in slice i
//   dn_*                       single downstream slave port
//   wr_grant, rd_grant         one-hot current owner, zero when idle
//   wr_state_dbg, rd_state_dbg current FSM state of each path
//   timeout_err                sticky response-timeout flag (only with
//                              AXI4LITE_ARB_TIMEOUT_EN defined)
// Optional feature macro: AXI4LITE_ARB_TIMEOUT_EN.
//
// Handshake semantics: a beat transfers on a rising edge where valid and ready
// are both high. Once a path is granted, the owner's valid/ready are routed
// combinationally to the slave and back; nothing is routed while a path is
// idle, so an upstream valid never produces a same-cycle upstream ready.
module axi4lite_rr_arbiter
    import axi4lite_arb_pkg::*;
#(
    parameter int NUM_M       = DEF_NUM_M,
    parameter int AW          = DEF_AW,
    parameter int DW          = DEF_DW,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_M*AW-1:0]   up_awaddr,
    input  logic [NUM_M-1:0]      up_awvalid,
    output logic [NUM_M-1:0]      up_awready,
    input  logic [NUM_M*DW-1:0]   up_wdata,
    input  logic [NUM_M*DW/8-1:0] up_wstrb,
    input  logic [NUM_M-1:0]      up_wvalid,
    output logic [NUM_M-1:0]      up_wready,
    output logic [NUM_M*2-1:0]    up_bresp,
    output logic [NUM_M-1:0]      up_bvalid,
    input  logic [NUM_M-1:0]      up_bready,
    input  logic [NUM_M*AW-1:0]   up_araddr,
    input  logic [NUM_M-1:0]      up_arvalid,
    output logic [NUM_M-1:0]      up_arready,
    output logic [NUM_M*DW-1:0]   up_rdata,
    output logic [NUM_M*2-1:0]    up_rresp,
    output logic [NUM_M-1:0]      up_rvalid,
    input  logic [NUM_M-1:0]      up_rready,
    output logic [AW-1:0]         dn_awaddr,
    output logic                  dn_awvalid,
    input  logic                  dn_awready,
    output logic [DW-1:0]         dn_wdata,
    output logic [DW/8-1:0]       dn_wstrb,
    output logic                  dn_wvalid,
    input  logic                  dn_wready,
    input  logic [1:0]            dn_bresp,
    input  logic                  dn_bvalid,
    output logic                  dn_bready,
    output logic [AW-1:0]         dn_araddr,
    output logic                  dn_arvalid,
    input  logic                  dn_arready,
    input  logic [DW-1:0]         dn_rdata,
    input  logic [1:0]            dn_rresp,
    input  logic                  dn_rvalid,
    output logic                  dn_rready,
    output logic [NUM_M-1:0]      wr_grant,
    output logic [NUM_M-1:0]      rd_grant,
    output logic [1:0]            wr_state_dbg,
    output logic [1:0]            rd_state_dbg
`ifdef AXI4LITE_ARB_TIMEOUT_EN
   ,output logic                  timeout_err
`endif
);

    localparam int PW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int SW = DW / 8;

    wr_state_t        wr_state, wr_state_nx;
    rd_state_t        rd_state, rd_state_nx;
    logic [PW-1:0]    wr_idx, wr_ptr, wr_pick_idx;
    logic [PW-1:0]    rd_idx, rd_ptr, rd_pick_idx;
    logic [NUM_M-1:0] wr_pick, rd_pick;
    logic             wr_any, rd_any;
    logic             aw_done, w_done;
    logic             aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic             wr_to_hit, rd_to_hit, wr_sink, rd_sink;

    assign wr_state_dbg = wr_state;
    assign rd_state_dbg = rd_state;

    axi4lite_rr_pick #(.N(NUM_M), .PW(PW)) u_wr_pick (
        .req   (up_awvalid | up_wvalid),
        .ptr   (wr_ptr),
        .grant (wr_pick),
        .idx   (wr_pick_idx),
        .any   (wr_any)
    );

    axi4lite_rr_pick #(.N(NUM_M), .PW(PW)) u_rd_pick (
        .req   (up_arvalid),
        .ptr   (rd_ptr),
        .grant (rd_pick),
        .idx   (rd_pick_idx),
        .any   (rd_any)
    );

    // ---------------- write path: next state and routing ----------------
    always_comb begin
        int ws;
        ws          = int'(wr_idx);
        wr_state_nx = wr_state;
        dn_awaddr   = '0;
        dn_awvalid  = 1'b0;
        dn_wdata    = '0;
        dn_wstrb    = '0;
        dn_wvalid   = 1'b0;
        dn_bready   = 1'b0;
        up_awready  = '0;
        up_wready   = '0;
        up_bvalid   = '0;
        up_bresp    = {NUM_M{RESP_OKAY}};
        aw_hs       = 1'b0;
        w_hs        = 1'b0;
        b_hs        = 1'b0;
        case (wr_state)
            W_IDLE: begin
                dn_bready = wr_sink;   // swallow a response that arrived after a timeout
                if (wr_any) wr_state_nx = W_ADDR;
            end
            W_ADDR: begin
                // A completed channel stays masked so it is not issued twice.
                dn_awaddr      = up_awaddr[ws*AW +: AW];
                dn_awvalid     = up_awvalid[wr_idx] & ~aw_done;
                dn_wdata       = up_wdata[ws*DW +: DW];
                dn_wstrb       = up_wstrb[ws*SW +: SW];
                dn_wvalid      = up_wvalid[wr_idx] & ~w_done;
                up_awready[wr_idx] = dn_awready & ~aw_done;
                up_wready[wr_idx]  = dn_wready & ~w_done;
                aw_hs = dn_awvalid & dn_awready;
                w_hs  = dn_wvalid & dn_wready;
                if ((aw_done | aw_hs) && (w_done | w_hs)) wr_state_nx = W_RESP;
            end
            W_RESP: begin
                if (wr_to_hit) begin
                    up_bvalid[wr_idx]    = 1'b1;
                    up_bresp[ws*2 +: 2]  = RESP_SLVERR;
                    b_hs                 = up_bready[wr_idx];
                end else begin
                    dn_bready            = up_bready[wr_idx];
                    up_bvalid[wr_idx]    = dn_bvalid;
                    up_bresp[ws*2 +: 2]  = dn_bresp;
                    b_hs                 = dn_bvalid & up_bready[wr_idx];
                end
                if (b_hs) wr_state_nx = W_IDLE;
            end
            default: wr_state_nx = W_IDLE;
        endcase
    end

    // ---------------- read path: next state and routing ----------------
    always_comb begin
        int rs;
        rs          = int'(rd_idx);
        rd_state_nx = rd_state;
        dn_araddr   = '0;
        dn_arvalid  = 1'b0;
        dn_rready   = 1'b0;
        up_arready  = '0;
        up_rvalid   = '0;
        up_rdata    = '0;
        up_rresp    = {NUM_M{RESP_OKAY}};
        ar_hs       = 1'b0;
        r_hs        = 1'b0;
        case (rd_state)
            R_IDLE: begin
                dn_rready = rd_sink;
                if (rd_any) rd_state_nx = R_ADDR;
            end
            R_ADDR: begin
                dn_araddr          = up_araddr[rs*AW +: AW];
                dn_arvalid         = up_arvalid[rd_idx];
                up_arready[rd_idx] = dn_arready;
                ar_hs = dn_arvalid & dn_arready;
                if (ar_hs) rd_state_nx = R_DATA;
            end
            R_DATA: begin
                if (rd_to_hit) begin
                    up_rvalid[rd_idx]   = 1'b1;
                    up_rresp[rs*2 +: 2] = RESP_SLVERR;
                    r_hs                = up_rready[rd_idx];
                end else begin
                    dn_rready             = up_rready[rd_idx];
                    up_rvalid[rd_idx]     = dn_rvalid;
                    up_rdata[rs*DW +: DW] = dn_rdata;
                    up_rresp[rs*2 +: 2]   = dn_rresp;
                    r_hs                  = dn_rvalid & up_rready[rd_idx];
                end
                if (r_hs) rd_state_nx = R_IDLE;
            end
            default: rd_state_nx = R_IDLE;
        endcase
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state <= W_IDLE;
            wr_grant <= '0;
            wr_idx   <= '0;
            wr_ptr   <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            wr_state <= wr_state_nx;
            case (wr_state)
                W_IDLE: if (wr_any) begin
                    wr_grant <= wr_pick;
                    wr_idx   <= wr_pick_idx;
                    aw_done  <= 1'b0;
                    w_done   <= 1'b0;
                end
                W_ADDR: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                end
                W_RESP: if (b_hs) begin
                    wr_grant <= '0;
                    wr_ptr   <= (wr_idx == PW'(NUM_M - 1)) ? '0 : wr_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state <= R_IDLE;
            rd_grant <= '0;
            rd_idx   <= '0;
            rd_ptr   <= '0;
        end else begin
            rd_state <= rd_state_nx;
            case (rd_state)
                R_IDLE: if (rd_any) begin
                    rd_grant <= rd_pick;
                    rd_idx   <= rd_pick_idx;
                end
                R_DATA: if (r_hs) begin
                    rd_grant <= '0;
                    rd_ptr   <= (rd_idx == PW'(NUM_M - 1)) ? '0 : rd_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef AXI4LITE_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] wr_cnt, rd_cnt;
    logic          wr_to_fire, rd_to_fire;

    // Fires on the edge that completes TIMEOUT_CYC silent response cycles.
    assign wr_to_fire = (wr_state == W_RESP) && !wr_to_hit && !dn_bvalid &&
                        (wr_cnt == TW'(TIMEOUT_CYC - 1));
    assign rd_to_fire = (rd_state == R_DATA) && !rd_to_hit && !dn_rvalid &&
                        (rd_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            wr_to_hit   <= 1'b0;
            rd_to_hit   <= 1'b0;
            wr_sink     <= 1'b0;
            rd_sink     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (wr_state != W_RESP) begin
                wr_cnt    <= '0;
                wr_to_hit <= 1'b0;
            end else if (wr_to_fire) begin
                wr_to_hit <= 1'b1;
            end else if (!wr_to_hit && !dn_bvalid) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
            if (rd_state != R_DATA) begin
                rd_cnt    <= '0;
                rd_to_hit <= 1'b0;
            end else if (rd_to_fire) begin
                rd_to_hit <= 1'b1;
            end else if (!rd_to_hit && !dn_rvalid) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
            if (wr_state == W_RESP && wr_to_hit && b_hs)  wr_sink <= 1'b1;
            else if (wr_state == W_IDLE && dn_bvalid)     wr_sink <= 1'b0;
            if (rd_state == R_DATA && rd_to_hit && r_hs)  rd_sink <= 1'b1;
            else if (rd_state == R_IDLE && dn_rvalid)     rd_sink <= 1'b0;
            if (wr_to_fire || rd_to_fire) timeout_err <= 1'b1;
        end
    end
`else
    // Without the timeout the block simply waits for every response.
    assign wr_to_hit = 1'b0;
    assign rd_to_hit = 1'b0;
    assign wr_sink   = 1'b0;
    assign rd_sink   = 1'b0;
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYC > 0) ^ RESP_SLVERR[1];
`endif

endmodule
